// File: rtl/aes_output_buffer.sv
// Output buffer for the AES core: holds finished 128-bit blocks and streams
// each one out as four 32-bit words, with an optional single pending slot.
module aes_output_buffer #(
  parameter int unsigned PEND_EN = 1,
  localparam int unsigned BLK_W  = 128,
  localparam int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [BLK_W-1:0]  text_i,
  input  logic              rd_ready_i,
  output logic [WORD_W-1:0] text_out,
  output logic              valid_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              full_o,
  output logic              ovf_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W0   = 3'd1,
    W1   = 3'd2,
    W2   = 3'd3,
    W3   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BLK_W-1:0]    active_q, active_d;
  logic [BLK_W-1:0]    pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                ovf_q, ovf_d;
  logic [WORD_W-1:0]   text_out_q, text_out_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;

  logic                xfer_c;
  logic                w3_xfer_c;
  logic                w3_reload_c;

  function automatic logic [WORD_W-1:0] sel_word(state_e s, logic [BLK_W-1:0] blk);
    logic [WORD_W-1:0] w;
    w = '0;
    case (s)
      W0:      w = blk[31:0];
      W1:      w = blk[63:32];
      W2:      w = blk[95:64];
      W3:      w = blk[127:96];
      default: w = '0;
    endcase
    return w;
  endfunction

  assign xfer_c      = valid_q & rd_ready_i;
  assign w3_xfer_c   = (state_q == W3) & rd_ready_i;
  // A done_i that lands directly in the active register on the W3 hand-off.
  assign w3_reload_c = w3_xfer_c & ~pend_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      text_out_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      text_out_q <= text_out_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (done_i) begin
          active_d = text_i;
          state_d  = W0;
        end
      end
      W0: if (xfer_c) state_d = W1;
      W1: if (xfer_c) state_d = W2;
      W2: if (xfer_c) state_d = W3;
      W3: begin
        if (xfer_c) begin
          if (pend_vld_q) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
            state_d    = W0;
          end else if (done_i) begin
            active_d = text_i;
            state_d  = W0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Busy-time arrivals go to the pending slot if it is (or is becoming) free.
    if (done_i && (state_q != IDLE) && !w3_reload_c) begin
      if ((PEND_EN != 0) && (!pend_vld_q || w3_xfer_c)) begin
        pend_d     = text_i;
        pend_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    text_out_d = sel_word(state_d, active_d);
    valid_d    = (state_d != IDLE);
    last_d     = (state_d == W3);
    busy_d     = (state_d != IDLE) | pend_vld_d;
    full_d     = (PEND_EN != 0) ? pend_vld_d : busy_d;
  end

  assign text_out = text_out_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign busy_o   = busy_q;
  assign full_o   = full_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_aes_output_buffer.sv
// Scoreboard bench for aes_output_buffer: stimulus queues expected words,
// a negedge monitor checks every transferred word against the queue.
module tb_aes_output_buffer;

  logic         clk;
  logic         rst;
  logic         done_i;
  logic [127:0] text_i;
  logic         rd_ready_i;
  logic [31:0]  text_out;
  logic         valid_o;
  logic         last_o;
  logic         busy_o;
  logic         full_o;
  logic         ovf_o;

  int tests;
  int fails;
  logic [32:0] exp_q[$];

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] BLK_C = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_D = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

  aes_output_buffer #(.PEND_EN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .done_i     (done_i),
    .text_i     (text_i),
    .rd_ready_i (rd_ready_i),
    .text_out   (text_out),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .full_o     (full_o),
    .ovf_o      (ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_block(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), b[32*i +: 32]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: a word is consumed on every cycle with valid_o && rd_ready_i.
  always @(negedge clk) begin
    if (rst && valid_o && rd_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got %h last=%b, scoreboard empty at %0t", text_out, last_o, $time);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({last_o, text_out} !== e) begin
          fails++;
          $display("FAIL word: got %h last=%b expected %h last=%b at %0t",
                   text_out, last_o, e[31:0], e[32], $time);
        end
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    done_i = 1'b0;
    text_i = '0;
    rd_ready_i = 1'b0;
    #1;
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_text", text_out, 32'd0);
    check("reset_flags", {28'd0, last_o, busy_o, full_o, ovf_o}, 32'd0);
    idle_n(2);
    rst = 1'b1;

    // Single block, always ready; done in the first clock after release
    rd_ready_i = 1'b1;
    done_i = 1'b1; text_i = BLK_A; push_block(BLK_A);
    step();
    done_i = 1'b0;
    check("latency_valid", 32'(valid_o), 32'd1);
    check("latency_word0", text_out, 32'hCCDDEEFF);
    check("busy_after_capture", 32'(busy_o), 32'd1);
    idle_n(4);
    check("single_idle_valid", 32'(valid_o), 32'd0);
    check("single_idle_busy", 32'(busy_o), 32'd0);

    // Backpressure in W1
    done_i = 1'b1; text_i = BLK_A; push_block(BLK_A);
    step();
    done_i = 1'b0;
    step();
    rd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_text", text_out, 32'h8899AABB);
      check("bp_valid", 32'(valid_o), 32'd1);
      step();
    end
    check("bp_text_end", text_out, 32'h8899AABB);
    rd_ready_i = 1'b1;
    idle_n(4);
    check("bp_idle", 32'(valid_o), 32'd0);

    // Back-to-back: block B arrives while A is in W1
    done_i = 1'b1; text_i = BLK_A; push_block(BLK_A);
    step();
    done_i = 1'b0;
    step();
    done_i = 1'b1; text_i = BLK_B; push_block(BLK_B);
    step();
    done_i = 1'b0;
    check("b2b_full", 32'(full_o), 32'd1);
    idle_n(9);
    check("b2b_ovf", 32'(ovf_o), 32'd0);
    check("b2b_full_end", 32'(full_o), 32'd0);
    check("b2b_busy_end", 32'(busy_o), 32'd0);

    // Same-cycle: done coincides with the W3 transfer
    done_i = 1'b1; text_i = BLK_C; push_block(BLK_C);
    step();
    done_i = 1'b0;
    idle_n(3);
    check("sc_in_w3", 32'(last_o), 32'd1);
    done_i = 1'b1; text_i = BLK_D; push_block(BLK_D);
    step();
    done_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("sc_valid_held", 32'(valid_o), 32'd1);
      step();
    end
    check("sc_idle", 32'(valid_o), 32'd0);
    check("sc_ovf", 32'(ovf_o), 32'd0);

    // Overflow: third block while active and pending are held
    rd_ready_i = 1'b0;
    done_i = 1'b1; text_i = BLK_A; push_block(BLK_A);
    step();
    check("ovf_full_early", 32'(full_o), 32'd0);
    done_i = 1'b1; text_i = BLK_B; push_block(BLK_B);
    step();
    check("ovf_full", 32'(full_o), 32'd1);
    check("ovf_pre", 32'(ovf_o), 32'd0);
    done_i = 1'b1; text_i = BLK_C;
    step();
    done_i = 1'b0;
    check("ovf_set", 32'(ovf_o), 32'd1);
    check("ovf_hold_word", text_out, 32'hCCDDEEFF);
    rd_ready_i = 1'b1;
    idle_n(10);
    check("ovf_drained", 32'(valid_o), 32'd0);
    check("ovf_sticky", 32'(ovf_o), 32'd1);

    // Reset clears the sticky flag
    rst = 1'b0;
    #1;
    check("rst_ovf", 32'(ovf_o), 32'd0);
    step();
    rst = 1'b1;

    // Reset mid-block in W2
    done_i = 1'b1; text_i = BLK_B; push_block(BLK_B);
    step();
    done_i = 1'b0;
    idle_n(2);
    check("mid_in_w2", text_out, 32'h01234567);
    rst = 1'b0;
    #1;
    check("mid_valid_async", 32'(valid_o), 32'd0);
    check("mid_text_async", text_out, 32'd0);
    exp_q.delete();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_quiet", 32'(valid_o), 32'd0);
    end
    done_i = 1'b1; text_i = BLK_D; push_block(BLK_D);
    step();
    done_i = 1'b0;
    check("mid_restart_word0", text_out, 32'hF0F0F0F0);
    idle_n(5);
    check("mid_end_idle", 32'(valid_o), 32'd0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
